gate_deadtime: RTL and testbench
================================

GATE_DEADTIME -- requirements
Module: gate_deadtime

Interface
REQ-001 SHALL have parameter DEAD, default 4: minimum counted both-off cycles before any gate turns on (1..15).
REQ-002 SHALL have parameter MIN_ON, default 3: minimum gate on-time in clock cycles (1..15).
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port hs_req  input  1  high-side on request from the PWM stage's syncRectifierHs output.
REQ-006 SHALL have port ls_req  input  1  low-side on request from the PWM stage's syncRectifierLs output.
REQ-007 SHALL have port oc  input  1  asynchronous overcurrent comparator, active-high.
REQ-008 SHALL have port fault_clr  input  1  synchronous fault clear request.
REQ-009 SHALL have port gate_hs  output  1  registered high-side gate drive.
REQ-010 SHALL have port gate_ls  output  1  registered low-side gate drive.
REQ-011 SHALL have port fault  output  1  high while in FAULT.
REQ-012 SHALL have port fault_cnt  output  4  count of FAULT entries.

Function
REQ-013 SHALL implement states IDLE (both gates 0), HS_ON (gate_hs=1), LS_ON (gate_ls=1), FAULT (both 0); gate_hs and gate_ls SHALL never be 1 together.
REQ-014 SHALL pass oc through a 2-flop synchronizer; oc_s is the second flop output.
REQ-015 SHALL keep off_cnt (4 bit): +1 per edge in IDLE, saturating at DEAD; cleared to 0 on every edge in HS_ON, LS_ON or FAULT.
REQ-016 SHALL treat hs_req=ls_req=1 as both requests low (illegal input).
REQ-017 IDLE -> HS_ON on an edge where hs_req=1, ls_req=0, off_cnt==DEAD, oc_s=0; IDLE -> LS_ON likewise for ls_req.
REQ-018 SHALL keep on_cnt (4 bit): set to 1 on entry to HS_ON/LS_ON, +1 per edge while on, saturating at 15.
REQ-019 HS_ON -> IDLE on an edge where on_cnt>=MIN_ON and effective hs_req=0; LS_ON symmetric; direct HS_ON<->LS_ON transition is forbidden.
REQ-020 Resulting both-off gap between one gate falling and the other rising SHALL be at least DEAD+1 clock cycles.
REQ-021 Any state -> FAULT on an edge where oc_s=1; fault overrides MIN_ON; gates go 0 on that same edge.
REQ-022 On FAULT entry fault_cnt SHALL increment, saturating at 15; cleared only by reset.
REQ-023 FAULT -> IDLE on an edge where fault_clr=1 and oc_s=0; fault_clr with oc_s=1 SHALL be ignored; off_cnt starts at 0 on exit.
REQ-024 Request-to-gate latency SHALL be one edge when off_cnt==DEAD; oc-to-gate-off latency SHALL be 3 edges.

Reset
REQ-025 reset low SHALL immediately force gate_hs=0, gate_ls=0, fault=0, fault_cnt=0, state IDLE, off_cnt=0, on_cnt=0, synchronizer flops 0.
REQ-026 Reset asserted mid-HS_ON/LS_ON SHALL drop the gate without waiting for a clock or MIN_ON.
REQ-027 After reset release the first gate turn-on SHALL occur no earlier than edge DEAD+1.

Verification (DEAD=4, MIN_ON=3)
REQ-028 Release reset, hold hs_req=1 -> gate_hs rises after edge 5, gate_ls stays 0.
REQ-029 In HS_ON (on_cnt>=3), same cycle hs_req 1->0 and ls_req 0->1 -> gate_hs falls at next edge k, gate_ls rises after edge k+5, both 0 in between.
REQ-030 1-cycle hs_req pulse from IDLE with off_cnt=4 -> gate_hs high exactly 3 cycles.
REQ-031 hs_req=ls_req=1 held in IDLE -> no gate ever asserts; both asserted during HS_ON -> exit to IDLE once on_cnt>=3.
REQ-032 oc pulses high during LS_ON -> gate_ls 0 and fault=1 after 3rd edge, fault_cnt 0->1; fault_clr with oc high ignored; fault_clr after oc low -> IDLE, next gate no sooner than 5 edges later; 16 faults -> fault_cnt holds 15.
REQ-033 Assert reset asynchronously mid-HS_ON -> gate_hs 0 before next clock edge, fault_cnt 0.

Source files
------------

// File: rtl/gate_deadtime.sv
// ---------------------------------------------------------------------------
// gate_deadtime
//   Half-bridge gate driver sequencer. Converts the high-side / low-side on
//   requests of the PWM stage into registered gate drives. It guarantees:
//     * the two gates are never on together,
//     * a counted both-off dead time before any gate turns on,
//     * a minimum on-time once a gate is on,
//     * a latched fault shutdown on overcurrent.
//
// Parameters
//   DEAD      minimum counted both-off cycles before a gate turns on (1..15)
//   MIN_ON    minimum gate on-time in clock cycles (1..15)
//
// Ports
//   clk        in   sole clock, rising edge
//   reset      in   asynchronous reset, active low
//   hs_req     in   high-side on request
//   ls_req     in   low-side on request
//   oc         in   overcurrent comparator, asynchronous, active high
//   fault_clr  in   synchronous fault clear request
//   gate_hs    out  registered high-side gate drive
//   gate_ls    out  registered low-side gate drive
//   fault      out  high while latched in FAULT
//   fault_cnt  out  saturating count of FAULT entries (cleared by reset only)
// ---------------------------------------------------------------------------
module gate_deadtime #(
  parameter int DEAD   = 4,
  parameter int MIN_ON = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       hs_req,
  input  logic       ls_req,
  input  logic       oc,
  input  logic       fault_clr,
  output logic       gate_hs,
  output logic       gate_ls,
  output logic       fault,
  output logic [3:0] fault_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HS_ON = 2'd1,
    LS_ON = 2'd2,
    FAULT = 2'd3
  } state_t;

  localparam logic [3:0] DEAD_C  = 4'(DEAD);
  localparam logic [3:0] MINON_C = 4'(MIN_ON);
  localparam logic [3:0] CNT_MAX = 4'd15;

  // Saturating 4-bit increment used by all counters.
  function automatic logic [3:0] satInc(input logic [3:0] value, input logic [3:0] limit);
    if (value >= limit) begin
      satInc = limit;
    end else begin
      satInc = value + 4'd1;
    end
  endfunction

  state_t     state_r;
  state_t     nextState_s;
  logic       ocMeta_r;
  logic       ocSync_r;
  logic [3:0] offCnt_r;
  logic [3:0] offCntNext_s;
  logic [3:0] onCnt_r;
  logic [3:0] onCntNext_s;
  logic [3:0] faultCnt_r;
  logic [3:0] faultCntNext_s;
  logic       gateHs_r;
  logic       gateLs_r;
  logic       fault_r;
  logic       hsEff_s;
  logic       lsEff_s;

  // Both requests together are contradictory, so they cancel each other.
  assign hsEff_s = hs_req & ~ls_req;
  assign lsEff_s = ls_req & ~hs_req;

  // Two-flop synchronizer for the asynchronous overcurrent comparator.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ocMeta_r <= 1'b0;
      ocSync_r <= 1'b0;
    end else begin
      ocMeta_r <= oc;
      ocSync_r <= ocMeta_r;
    end
  end

  // Next-state decode; a synchronized overcurrent wins over everything,
  // including the minimum on-time.
  always_comb begin
    nextState_s = state_r;
    if (ocSync_r) begin
      nextState_s = FAULT;
    end else begin
      case (state_r)
        IDLE: begin
          if (hsEff_s && (offCnt_r == DEAD_C)) begin
            nextState_s = HS_ON;
          end else if (lsEff_s && (offCnt_r == DEAD_C)) begin
            nextState_s = LS_ON;
          end else begin
            nextState_s = IDLE;
          end
        end
        HS_ON: begin
          // Always return through IDLE so the dead time is re-counted.
          if ((onCnt_r >= MINON_C) && !hsEff_s) begin
            nextState_s = IDLE;
          end else begin
            nextState_s = HS_ON;
          end
        end
        LS_ON: begin
          if ((onCnt_r >= MINON_C) && !lsEff_s) begin
            nextState_s = IDLE;
          end else begin
            nextState_s = LS_ON;
          end
        end
        FAULT: begin
          // ocSync_r is known low here, so a clear request is honoured.
          if (fault_clr) begin
            nextState_s = IDLE;
          end else begin
            nextState_s = FAULT;
          end
        end
        default: begin
          nextState_s = FAULT;
        end
      endcase
    end
  end

  // Counter next values: dead-time, on-time and fault-entry counters.
  always_comb begin
    offCntNext_s   = 4'd0;
    onCntNext_s    = 4'd0;
    faultCntNext_s = faultCnt_r;

    // Dead time only accumulates while both gates are idle; leaving FAULT
    // therefore always starts from zero.
    if (state_r == IDLE) begin
      offCntNext_s = satInc(offCnt_r, DEAD_C);
    end else begin
      offCntNext_s = 4'd0;
    end

    if ((nextState_s == HS_ON) || (nextState_s == LS_ON)) begin
      if (nextState_s == state_r) begin
        onCntNext_s = satInc(onCnt_r, CNT_MAX);
      end else begin
        onCntNext_s = 4'd1;
      end
    end else begin
      onCntNext_s = 4'd0;
    end

    if ((nextState_s == FAULT) && (state_r != FAULT)) begin
      faultCntNext_s = satInc(faultCnt_r, CNT_MAX);
    end else begin
      faultCntNext_s = faultCnt_r;
    end
  end

  // State, counters and registered outputs; gates follow the next state so
  // they change on the same edge as the state transition.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= IDLE;
      offCnt_r   <= 4'd0;
      onCnt_r    <= 4'd0;
      faultCnt_r <= 4'd0;
      gateHs_r   <= 1'b0;
      gateLs_r   <= 1'b0;
      fault_r    <= 1'b0;
    end else begin
      state_r    <= nextState_s;
      offCnt_r   <= offCntNext_s;
      onCnt_r    <= onCntNext_s;
      faultCnt_r <= faultCntNext_s;
      gateHs_r   <= (nextState_s == HS_ON);
      gateLs_r   <= (nextState_s == LS_ON);
      fault_r    <= (nextState_s == FAULT);
    end
  end

  assign gate_hs   = gateHs_r;
  assign gate_ls   = gateLs_r;
  assign fault     = fault_r;
  assign fault_cnt = faultCnt_r;

endmodule

// File: tb/tb_gate_deadtime.sv
// ---------------------------------------------------------------------------
// tb_gate_deadtime
//   Directed bench for gate_deadtime (DEAD=4, MIN_ON=3). A table of
//   {inputs, expected outputs} rows is applied one clock edge per row and
//   compared #1 after the edge, followed by hand-written sequences for
//   repeated faults and asynchronous reset.
// ---------------------------------------------------------------------------
module tb_gate_deadtime;

  logic       clk = 1'b0;
  logic       reset;
  logic       hs_req;
  logic       ls_req;
  logic       oc;
  logic       fault_clr;
  logic       gate_hs;
  logic       gate_ls;
  logic       fault;
  logic [3:0] fault_cnt;

  int nVec = 0;
  int nErr = 0;

  typedef struct {
    logic       hs;
    logic       ls;
    logic       oc;
    logic       clr;
    logic [6:0] exp;  // {gate_hs, gate_ls, fault, fault_cnt}
  } vec_t;

  vec_t tbl[$];

  gate_deadtime #(.DEAD(4), .MIN_ON(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .hs_req    (hs_req),
    .ls_req    (ls_req),
    .oc        (oc),
    .fault_clr (fault_clr),
    .gate_hs   (gate_hs),
    .gate_ls   (gate_ls),
    .fault     (fault),
    .fault_cnt (fault_cnt)
  );

  always #5 clk = ~clk;

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void add(input logic hs, input logic ls, input logic o, input logic clr,
                              input logic gh, input logic gl, input logic f, input logic [3:0] c);
    vec_t v;
    v.hs  = hs;
    v.ls  = ls;
    v.oc  = o;
    v.clr = clr;
    v.exp = {gh, gl, f, c};
    tbl.push_back(v);
  endfunction

  task automatic check(input string name, input logic [6:0] exp);
    logic [6:0] act;
    act = {gate_hs, gate_ls, fault, fault_cnt};
    nVec++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got hs=%b ls=%b fault=%b cnt=%0d, want hs=%b ls=%b fault=%b cnt=%0d",
               name, act[6], act[5], act[4], act[3:0], exp[6], exp[5], exp[4], exp[3:0]);
    end
  endtask

  task automatic drive(input logic hs, input logic ls, input logic o, input logic clr);
    hs_req    = hs;
    ls_req    = ls;
    oc        = o;
    fault_clr = clr;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0);

    // Table built as one continuous run from reset release (edge 1).
    // Hold hs_req: gate_hs rises after edge 5.
    for (int i = 0; i < 4; i++) add(1, 0, 0, 0, 0, 0, 0, 4'd0);
    for (int i = 0; i < 4; i++) add(1, 0, 0, 0, 1, 0, 0, 4'd0);          // e5..e8
    // Swap requests: gate_hs falls at e9, gate_ls rises at e14.
    add(0, 1, 0, 0, 0, 0, 0, 4'd0);                                      // e9
    for (int i = 0; i < 4; i++) add(0, 1, 0, 0, 0, 0, 0, 4'd0);          // e10..e13
    add(0, 1, 0, 0, 0, 1, 0, 4'd0);                                      // e14
    // Release ls_req immediately: MIN_ON keeps gate_ls for 3 cycles.
    for (int i = 0; i < 2; i++) add(0, 0, 0, 0, 0, 1, 0, 4'd0);          // e15,e16
    add(0, 0, 0, 0, 0, 0, 0, 4'd0);                                      // e17
    for (int i = 0; i < 4; i++) add(0, 0, 0, 0, 0, 0, 0, 4'd0);          // e18..e21
    // Single-cycle hs_req pulse with dead time complete: 3 cycles high.
    add(1, 0, 0, 0, 1, 0, 0, 4'd0);                                      // e22
    for (int i = 0; i < 2; i++) add(0, 0, 0, 0, 1, 0, 0, 4'd0);          // e23,e24
    add(0, 0, 0, 0, 0, 0, 0, 4'd0);                                      // e25
    // Both requests in IDLE: nothing turns on, even after dead time.
    for (int i = 0; i < 6; i++) add(1, 1, 0, 0, 0, 0, 0, 4'd0);          // e26..e31
    add(1, 0, 0, 0, 1, 0, 0, 4'd0);                                      // e32
    // Both requests during HS_ON: leave once on-time reaches 3.
    for (int i = 0; i < 2; i++) add(1, 1, 0, 0, 1, 0, 0, 4'd0);          // e33,e34
    for (int i = 0; i < 2; i++) add(1, 1, 0, 0, 0, 0, 0, 4'd0);          // e35,e36
    // Low side on, then overcurrent.
    for (int i = 0; i < 3; i++) add(0, 1, 0, 0, 0, 0, 0, 4'd0);          // e37..e39
    add(0, 1, 0, 0, 0, 1, 0, 4'd0);                                      // e40
    for (int i = 0; i < 2; i++) add(0, 1, 1, 0, 0, 1, 0, 4'd0);          // e41,e42
    add(0, 1, 1, 0, 0, 0, 1, 4'd1);                                      // e43 fault
    add(0, 1, 1, 1, 0, 0, 1, 4'd1);                                      // e44 clr ignored
    add(0, 1, 0, 1, 0, 0, 1, 4'd1);                                      // e45 oc_s still 1
    add(0, 1, 0, 0, 0, 0, 1, 4'd1);                                      // e46
    add(0, 1, 0, 1, 0, 0, 0, 4'd1);                                      // e47 cleared
    for (int i = 0; i < 4; i++) add(0, 1, 0, 0, 0, 0, 0, 4'd1);          // e48..e51
    add(0, 1, 0, 0, 0, 1, 0, 4'd1);                                      // e52

    repeat (3) step();
    check("reset_state", 7'b000_0000);
    reset = 1'b1;

    foreach (tbl[i]) begin
      drive(tbl[i].hs, tbl[i].ls, tbl[i].oc, tbl[i].clr);
      step();
      check($sformatf("vec%0d", i + 1), tbl[i].exp);
    end

    // Sixteen more faults: the entry counter saturates at 15.
    for (int i = 0; i < 16; i++) begin
      logic [3:0] expCnt;
      expCnt = (i + 2 > 15) ? 4'd15 : 4'(i + 2);
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      repeat (3) step();
      check($sformatf("fault_enter%0d", i), {3'b001, expCnt});
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      repeat (2) step();
      drive(1'b0, 1'b0, 1'b0, 1'b1);
      step();
      check($sformatf("fault_clear%0d", i), {3'b000, expCnt});
    end

    // From fault exit, the next gate needs 5 edges.
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (4) step();
    check("post_clr_edge4", 7'b000_1111);
    step();
    check("post_clr_edge5", 7'b100_1111);

    // Asynchronous reset mid-HS_ON drops the gate before the next edge.
    #3;
    reset = 1'b0;
    #1;
    check("async_reset", 7'b000_0000);
    step();
    reset = 1'b1;

    // After release, first turn-on no earlier than edge 5.
    repeat (4) step();
    check("rel_edge4", 7'b000_0000);
    step();
    check("rel_edge5", 7'b100_0000);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
